// File: rtl/mbtrain_pkg.sv
// rtl/mbtrain_pkg.sv - sideband encodings, exit codes and state type shared by MBTRAIN steps
package mbtrain_pkg;

    localparam logic [3:0] START_REQ                  = 4'd1;
    localparam logic [3:0] START_RESP                 = 4'd2;
    localparam logic [3:0] ERROR_REQ                  = 4'd3;
    localparam logic [3:0] ERROR_RESP                 = 4'd4;
    localparam logic [3:0] EXIT_TO_REPAIR_REQ         = 4'd5;
    localparam logic [3:0] EXIT_TO_REPAIR_RESP        = 4'd6;
    localparam logic [3:0] EXIT_TO_SPEED_DEGRADE_REQ  = 4'd7;
    localparam logic [3:0] EXIT_TO_SPEED_DEGRADE_RESP = 4'd8;
    localparam logic [3:0] DONE_REQ                   = 4'd9;
    localparam logic [3:0] DONE_RESP                  = 4'd10;
    localparam logic [3:0] EXIT_TO_PHYRETRAIN_REQ     = 4'd11;
    localparam logic [3:0] EXIT_TO_PHYRETRAIN_RESP    = 4'd12;

    // One-hot exit vector order: {done, repair, speed_degrade, phyretrain, timeout}
    localparam logic [4:0] EXIT_DONE          = 5'b10000;
    localparam logic [4:0] EXIT_REPAIR        = 5'b01000;
    localparam logic [4:0] EXIT_SPEED_DEGRADE = 5'b00100;
    localparam logic [4:0] EXIT_PHYRETRAIN    = 5'b00010;
    localparam logic [4:0] EXIT_TIMEOUT       = 5'b00001;

    typedef enum logic [3:0] {
        IDLE,
        SEND_START_REQ,
        WAIT_START_RESP,
        POINT_TEST,
        SEND_RESULT_REQ,
        WAIT_RESULT_RESP,
        SEND_EXIT_REQ,
        WAIT_EXIT_RESP,
        TEST_FINISH
    } state_e;

    function automatic logic [3:0] resp_for(input logic [3:0] req);
        case (req)
            START_REQ:                 resp_for = START_RESP;
            ERROR_REQ:                 resp_for = ERROR_RESP;
            EXIT_TO_REPAIR_REQ:        resp_for = EXIT_TO_REPAIR_RESP;
            EXIT_TO_SPEED_DEGRADE_REQ: resp_for = EXIT_TO_SPEED_DEGRADE_RESP;
            DONE_REQ:                  resp_for = DONE_RESP;
            EXIT_TO_PHYRETRAIN_REQ:    resp_for = EXIT_TO_PHYRETRAIN_RESP;
            default:                   resp_for = 4'd0;
        endcase
    endfunction

    function automatic logic is_wait(input state_e s);
        is_wait = (s == WAIT_START_RESP) || (s == WAIT_RESULT_RESP) || (s == WAIT_EXIT_RESP);
    endfunction

endpackage

// File: rtl/sb_valid_ctrl.sv
// rtl/sb_valid_ctrl.sv - sideband TX valid handshake with collision deferral and fall detect
module sb_valid_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic rx_valid,
    input  logic busy_negedge,
    output logic valid,
    output logic valid_fall
);

    logic active_q;
    logic valid_q;
    logic pending;
    logic entry;

    assign entry = active & ~active_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            valid_q  <= 1'b0;
            valid    <= 1'b0;
            pending  <= 1'b0;
        end else begin
            active_q <= active;
            valid_q  <= valid;
            if (!active) begin
                valid   <= 1'b0;
                pending <= 1'b0;
            end else if (busy_negedge) begin
                valid <= 1'b0;
                if (entry) pending <= 1'b1;
            end else if (entry || pending) begin
                // Hold off while the responder owns the sideband
                if (rx_valid) begin
                    pending <= 1'b1;
                end else begin
                    valid   <= 1'b1;
                    pending <= 1'b0;
                end
            end
        end
    end

    // active_q gating stops a stale fall from a previous send leaking into a fresh one
    assign valid_fall = valid_q & ~valid & active_q;

endmodule

// File: rtl/linkspeed_tx.sv
// rtl/linkspeed_tx.sv - initiator side of the MBTRAIN.LINKSPEED step
module linkspeed_tx
    import mbtrain_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 800000,
    parameter int CNT_W          = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_en,
    input  logic [3:0]  i_sideband_message,
    input  logic        i_rx_valid,
    input  logic        i_busy_negedge_detected,
    input  logic        i_point_test_ack,
    input  logic [15:0] i_lanes_result,
    input  logic        i_valid_framing_error,
    input  logic        i_phyretrain_req,
    input  logic        i_comming_from_repair,
    input  logic        i_first_8_tx_lanes_are_functional,
    input  logic        i_second_8_tx_lanes_are_functional,
    output logic [3:0]  o_sideband_message,
    output logic        o_valid_tx,
    output logic        o_point_test_en,
    output logic        o_test_ack,
    output logic        o_exit_done,
    output logic        o_exit_repair,
    output logic        o_exit_speed_degrade,
    output logic        o_exit_phyretrain,
    output logic        o_timeout
);

    state_e           state;
    state_e           next_state;
    logic [CNT_W-1:0] cnt;
    logic [15:0]      lanes_q;
    logic [4:0]       exit_q;
    logic [4:0]       exit_d;
    logic [3:0]       msg_d;
    logic             pt_en_d;
    logic             ack_d;
    logic             in_send;
    logic             valid_fall;
    logic             timeout_hit;
    logic             resp_ok;
    logic [3:0]       result_req;
    logic [3:0]       exit_req;

    assign in_send     = (state == SEND_START_REQ) || (state == SEND_RESULT_REQ) ||
                         (state == SEND_EXIT_REQ);
    assign timeout_hit = is_wait(state) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign resp_ok     = (i_sideband_message == resp_for(o_sideband_message));

    assign {o_exit_done, o_exit_repair, o_exit_speed_degrade, o_exit_phyretrain, o_timeout} = exit_q;

    sb_valid_ctrl u_valid (
        .clk          (clk),
        .rst_n        (rst_n),
        .active       (in_send),
        .rx_valid     (i_rx_valid),
        .busy_negedge (i_busy_negedge_detected),
        .valid        (o_valid_tx),
        .valid_fall   (valid_fall)
    );

    always_comb begin
        result_req = ERROR_REQ;
        if (i_phyretrain_req) begin
            result_req = EXIT_TO_PHYRETRAIN_REQ;
        end else if ((&i_lanes_result) && !i_valid_framing_error) begin
            result_req = DONE_REQ;
        end else if (i_comming_from_repair && !i_valid_framing_error &&
                     ((i_first_8_tx_lanes_are_functional && (&i_lanes_result[7:0])) ||
                      (i_second_8_tx_lanes_are_functional && (&i_lanes_result[15:8])))) begin
            result_req = DONE_REQ;
        end
    end

    // Repair is only worth trying once; a second failure degrades speed
    assign exit_req = (((&lanes_q[7:0]) || (&lanes_q[15:8])) && !i_comming_from_repair) ?
                      EXIT_TO_REPAIR_REQ : EXIT_TO_SPEED_DEGRADE_REQ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            if (state != next_state)  cnt <= '0;
            else if (is_wait(state))  cnt <= cnt + 1'b1;
            else                      cnt <= '0;
        end
    end

    always_comb begin
        next_state = state;
        if (!i_en) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:            next_state = SEND_START_REQ;
                SEND_START_REQ:  if (valid_fall) next_state = WAIT_START_RESP;
                WAIT_START_RESP: begin
                    if (resp_ok)          next_state = POINT_TEST;
                    else if (timeout_hit) next_state = TEST_FINISH;
                end
                POINT_TEST:      if (i_point_test_ack) next_state = SEND_RESULT_REQ;
                SEND_RESULT_REQ: if (valid_fall) next_state = WAIT_RESULT_RESP;
                WAIT_RESULT_RESP: begin
                    if (resp_ok)
                        next_state = (o_sideband_message == ERROR_REQ) ? SEND_EXIT_REQ : TEST_FINISH;
                    else if (timeout_hit)
                        next_state = TEST_FINISH;
                end
                SEND_EXIT_REQ:   if (valid_fall) next_state = WAIT_EXIT_RESP;
                WAIT_EXIT_RESP:  if (resp_ok || timeout_hit) next_state = TEST_FINISH;
                TEST_FINISH:     next_state = TEST_FINISH;
                default:         next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        msg_d   = o_sideband_message;
        pt_en_d = o_point_test_en;
        ack_d   = o_test_ack;
        exit_d  = exit_q;
        if (next_state == IDLE) begin
            msg_d   = 4'd0;
            pt_en_d = 1'b0;
            ack_d   = 1'b0;
            exit_d  = 5'd0;
        end else if (state != next_state) begin
            case (next_state)
                SEND_START_REQ:  msg_d = START_REQ;
                POINT_TEST:      pt_en_d = 1'b1;
                SEND_RESULT_REQ: begin
                    pt_en_d = 1'b0;
                    msg_d   = result_req;
                end
                SEND_EXIT_REQ:   msg_d = exit_req;
                TEST_FINISH: begin
                    ack_d = 1'b1;
                    if (!resp_ok) begin
                        exit_d = EXIT_TIMEOUT;
                    end else begin
                        case (o_sideband_message)
                            DONE_REQ:                  exit_d = EXIT_DONE;
                            EXIT_TO_PHYRETRAIN_REQ:    exit_d = EXIT_PHYRETRAIN;
                            EXIT_TO_REPAIR_REQ:        exit_d = EXIT_REPAIR;
                            EXIT_TO_SPEED_DEGRADE_REQ: exit_d = EXIT_SPEED_DEGRADE;
                            default:                   exit_d = EXIT_TIMEOUT;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_sideband_message <= 4'd0;
            o_point_test_en    <= 1'b0;
            o_test_ack         <= 1'b0;
            exit_q             <= 5'd0;
            lanes_q            <= 16'd0;
        end else begin
            o_sideband_message <= msg_d;
            o_point_test_en    <= pt_en_d;
            o_test_ack         <= ack_d;
            exit_q             <= exit_d;
            if (state == POINT_TEST && i_point_test_ack) lanes_q <= i_lanes_result;
        end
    end

endmodule

// File: tb/tb_linkspeed_tx.sv
// tb/tb_linkspeed_tx.sv - scoreboard bench for linkspeed_tx
module tb_linkspeed_tx;
    import mbtrain_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_en = 1'b0;
    logic [3:0]  i_sideband_message = 4'd0;
    logic        i_rx_valid = 1'b0;
    logic        i_busy_negedge_detected = 1'b0;
    logic        i_point_test_ack = 1'b0;
    logic [15:0] i_lanes_result = 16'd0;
    logic        i_valid_framing_error = 1'b0;
    logic        i_phyretrain_req = 1'b0;
    logic        i_comming_from_repair = 1'b0;
    logic        i_first_8 = 1'b0;
    logic        i_second_8 = 1'b0;
    logic [3:0]  o_sideband_message;
    logic        o_valid_tx, o_point_test_en, o_test_ack;
    logic        o_exit_done, o_exit_repair, o_exit_speed_degrade, o_exit_phyretrain, o_timeout;

    always #5 clk = ~clk;

    linkspeed_tx #(.TIMEOUT_CYCLES(50), .CNT_W(20)) dut (
        .clk                                (clk),
        .rst_n                              (rst_n),
        .i_en                               (i_en),
        .i_sideband_message                 (i_sideband_message),
        .i_rx_valid                         (i_rx_valid),
        .i_busy_negedge_detected            (i_busy_negedge_detected),
        .i_point_test_ack                   (i_point_test_ack),
        .i_lanes_result                     (i_lanes_result),
        .i_valid_framing_error              (i_valid_framing_error),
        .i_phyretrain_req                   (i_phyretrain_req),
        .i_comming_from_repair              (i_comming_from_repair),
        .i_first_8_tx_lanes_are_functional  (i_first_8),
        .i_second_8_tx_lanes_are_functional (i_second_8),
        .o_sideband_message                 (o_sideband_message),
        .o_valid_tx                         (o_valid_tx),
        .o_point_test_en                    (o_point_test_en),
        .o_test_ack                         (o_test_ack),
        .o_exit_done                        (o_exit_done),
        .o_exit_repair                      (o_exit_repair),
        .o_exit_speed_degrade               (o_exit_speed_degrade),
        .o_exit_phyretrain                  (o_exit_phyretrain),
        .o_timeout                          (o_timeout)
    );

    wire [4:0]  exits   = {o_exit_done, o_exit_repair, o_exit_speed_degrade, o_exit_phyretrain, o_timeout};
    wire [11:0] all_out = {o_sideband_message, o_valid_tx, o_point_test_en, o_test_ack, exits};

    int n_tests = 0;
    int n_fail  = 0;
    logic [3:0] msg_q[$];
    logic [4:0] exit_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every valid rise and every test_ack rise is matched against the scoreboard
    logic valid_prev = 1'b0;
    logic ack_prev   = 1'b0;
    always @(negedge clk) begin
        if (o_valid_tx && !valid_prev) begin
            if (msg_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL sb_msg_unexpected: got 0x%0h expected none", o_sideband_message);
            end else begin
                check("sb_msg", {28'd0, o_sideband_message}, {28'd0, msg_q.pop_front()});
            end
        end
        if (o_test_ack && !ack_prev) begin
            if (exit_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL exit_unexpected: got 0x%0h expected none", exits);
            end else begin
                check("exit_flags", {27'd0, exits}, {27'd0, exit_q.pop_front()});
            end
        end
        valid_prev = o_valid_tx;
        ack_prev   = o_test_ack;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_for(input int which, input string name);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < 300 && !hit; k++) begin
            tick(1);
            case (which)
                0:       hit = o_valid_tx;
                1:       hit = o_point_test_en;
                default: hit = o_test_ack;
            endcase
        end
        check({name, "_seen"}, {31'd0, hit}, 32'd1);
    endtask

    task automatic do_msg(input logic [3:0] exp);
        msg_q.push_back(exp);
        wait_for(0, "valid");
        tick(2);
        i_busy_negedge_detected = 1'b1;
        tick(1);
        i_busy_negedge_detected = 1'b0;
        check("valid_clear", {31'd0, o_valid_tx}, 32'd0);
    endtask

    task automatic respond(input logic [3:0] m);
        tick(3);
        i_sideband_message = m;
        tick(1);
        i_sideband_message = 4'd0;
    endtask

    task automatic point_test(input logic [15:0] lanes, input logic fr);
        wait_for(1, "pt_en");
        tick(2);
        i_lanes_result        = lanes;
        i_valid_framing_error = fr;
        i_point_test_ack      = 1'b1;
        tick(1);
        i_point_test_ack = 1'b0;
        check("pt_en_drop", {31'd0, o_point_test_en}, 32'd0);
    endtask

    task automatic finish_step();
        wait_for(2, "test_ack");
        i_en = 1'b0;
        tick(1);
        check("idle_outputs", {20'd0, all_out}, 32'd0);
        tick(2);
    endtask

    typedef struct packed {
        logic [15:0] lanes;
        logic        fr, phy, rep, f8, s8;
        logic [3:0]  res, ex, bogus, ex_resp;
        logic [4:0]  exit_exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        //           lanes     fr    phy   rep   f8    s8    res    ex     bogus  ex_resp exit
        vecs[0] = '{16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd9,  4'd0, 4'd0,  4'd10, 5'b10000};
        vecs[1] = '{16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  4'd5, 4'd0,  4'd6,  5'b01000};
        vecs[2] = '{16'h00FF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9,  4'd0, 4'd0,  4'd10, 5'b10000};
        vecs[3] = '{16'h0F0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3,  4'd7, 4'd0,  4'd8,  5'b00100};
        vecs[4] = '{16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd11, 4'd0, 4'd10, 4'd12, 5'b00010};
        vecs[5] = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3,  4'd5, 4'd0,  4'd6,  5'b01000};
        vecs[6] = '{16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd9,  4'd0, 4'd0,  4'd10, 5'b10000};
        vecs[7] = '{16'hFF00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3,  4'd7, 4'd0,  4'd8,  5'b00100};

        tick(3);
        check("reset_outputs", {20'd0, all_out}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("idle_after_reset", {20'd0, all_out}, 32'd0);

        foreach (vecs[i]) begin
            i_phyretrain_req      = vecs[i].phy;
            i_comming_from_repair = vecs[i].rep;
            i_first_8             = vecs[i].f8;
            i_second_8            = vecs[i].s8;
            i_en = 1'b1;
            do_msg(START_REQ);
            respond(START_RESP);
            point_test(vecs[i].lanes, vecs[i].fr);
            do_msg(vecs[i].res);
            if (vecs[i].ex != 4'd0) begin
                respond(ERROR_RESP);
                do_msg(vecs[i].ex);
            end
            if (vecs[i].bogus != 4'd0) begin
                respond(vecs[i].bogus);
                check("bogus_ignored", {31'd0, o_test_ack}, 32'd0);
            end
            exit_q.push_back(vecs[i].exit_exp);
            respond(vecs[i].ex_resp);
            finish_step();
        end
        i_phyretrain_req      = 1'b0;
        i_comming_from_repair = 1'b0;
        i_first_8             = 1'b0;
        i_second_8            = 1'b0;
        i_valid_framing_error = 1'b0;

        // Collision with responder valid at SEND_START_REQ entry
        msg_q.push_back(START_REQ);
        i_rx_valid = 1'b1;
        i_en       = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("valid_held_off", {31'd0, o_valid_tx}, 32'd0);
        end
        i_rx_valid = 1'b0;
        tick(1);
        check("valid_after_rx", {31'd0, o_valid_tx}, 32'd1);
        tick(2);
        i_busy_negedge_detected = 1'b1;
        tick(1);
        i_busy_negedge_detected = 1'b0;
        check("collision_valid_clear", {31'd0, o_valid_tx}, 32'd0);
        i_en = 1'b0;
        tick(1);
        check("collision_idle", {20'd0, all_out}, 32'd0);
        tick(2);

        // Timeout in WAIT_START_RESP
        i_en = 1'b1;
        do_msg(START_REQ);
        exit_q.push_back(5'b00001);
        tick(1);
        tick(49);
        check("timeout_early", {31'd0, o_timeout}, 32'd0);
        tick(1);
        check("timeout_flag", {31'd0, o_timeout}, 32'd1);
        check("timeout_ack", {31'd0, o_test_ack}, 32'd1);
        i_en = 1'b0;
        tick(1);
        check("timeout_idle", {20'd0, all_out}, 32'd0);
        tick(2);

        // Asynchronous reset during WAIT_RESULT_RESP
        i_en = 1'b1;
        do_msg(START_REQ);
        respond(START_RESP);
        point_test(16'hFFFF, 1'b0);
        do_msg(DONE_REQ);
        tick(3);
        check("pre_reset_msg", {28'd0, o_sideband_message}, {28'd0, DONE_REQ});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", {20'd0, all_out}, 32'd0);
        i_en = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // i_en dropped during POINT_TEST
        i_en = 1'b1;
        do_msg(START_REQ);
        respond(START_RESP);
        wait_for(1, "pt_en_abort");
        i_en = 1'b0;
        tick(1);
        check("abort_pt_en", {31'd0, o_point_test_en}, 32'd0);
        check("abort_idle", {20'd0, all_out}, 32'd0);
        tick(3);

        check("msg_q_drained", msg_q.size(), 32'd0);
        check("exit_q_drained", exit_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
